// File: rtl/imm_gen_pipe_if.sv
// Handshake and data bundle for imm_gen_pipe.
// slave: the generator side; master: the producer/consumer side.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instruction_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] imm_o;
  logic [2:0]      fmt_o;
  logic            illegal_o;
`ifdef IMM_PC_TARGET_EN
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] target_o;
`endif

  modport slave (
    input  flush_i, in_valid_i, instruction_i, out_ready_i,
`ifdef IMM_PC_TARGET_EN
    input  pc_i,
    output target_o,
`endif
    output in_ready_o, out_valid_o, instr_o, imm_o, fmt_o,
    output illegal_o
  );

  modport master (
    output flush_i, in_valid_i, instruction_i, out_ready_i,
`ifdef IMM_PC_TARGET_EN
    output pc_i,
    input  target_o,
`endif
    input  in_ready_o, out_valid_o, instr_o, imm_o, fmt_o,
    input  illegal_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with 2-entry skid buffer (O + K).
// Ports: clk, reset (sync, active-high), bus (imm_gen_pipe_if.slave).
// Optional macro IMM_PC_TARGET_EN adds pc_i/target_o (pc + imm).
module imm_gen_pipe #(
  parameter int XLEN         = 32,
  parameter int DROP_ILLEGAL = 0
) (
  input logic              clk,
  input logic              reset,
  imm_gen_pipe_if.slave    bus
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
`ifdef IMM_PC_TARGET_EN
    logic [XLEN-1:0] target;
`endif
  } entry_t;

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;

  logic [31:0] inst;
  logic [6:0]  op;
  logic        is_i, is_s, is_b, is_u, is_j;
  logic [31:0] raw;
  entry_t      dec;

  assign inst = bus.instruction_i;
  assign op   = inst[6:0];

  assign is_i = (op == 7'b0010011) | (op == 7'b0000011) |
                (op == 7'b1100111) | (op == 7'b1110011);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = (op == 7'b0110111) | (op == 7'b0010111);
  assign is_j = (op == 7'b1101111);

  always_comb begin
    raw         = '0;
    dec         = '0;
    dec.instr   = inst;
    dec.illegal = 1'b0;
    unique case (1'b1)
      is_i: begin
        raw     = {{20{inst[31]}}, inst[31:20]};
        dec.fmt = F_I;
      end
      is_s: begin
        raw     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        dec.fmt = F_S;
      end
      is_b: begin
        raw     = {{19{inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};
        dec.fmt = F_B;
      end
      is_u: begin
        raw     = {inst[31:12], 12'b0};
        dec.fmt = F_U;
      end
      is_j: begin
        raw     = {{11{inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};
        dec.fmt = F_J;
      end
      default: begin
        raw         = '0;
        dec.fmt     = F_NONE;
        dec.illegal = 1'b1;
      end
    endcase
    // all formats are already sign-extended to 32; widen signed
    dec.imm = XLEN'($signed(raw));
`ifdef IMM_PC_TARGET_EN
    dec.target = bus.pc_i + dec.imm;
`endif
  end

  entry_t o_q, k_q;
  logic   o_valid, k_valid;
  logic   accept, store, o_load;

  assign bus.in_ready_o = ~k_valid;
  assign accept = bus.in_valid_i & ~k_valid &
                  ~bus.flush_i & ~reset;
  // dropped illegals complete the handshake but are never stored
  assign store  = accept &
                  ~((DROP_ILLEGAL != 0) & dec.illegal);
  assign o_load = ~o_valid | bus.out_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      k_valid <= 1'b0;
      o_q     <= '0;
      k_q     <= '0;
    end else if (bus.flush_i) begin
      o_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (o_load) begin
      if (k_valid) begin
        o_q     <= k_q;
        o_valid <= 1'b1;
        k_valid <= store;
        if (store) k_q <= dec;
      end else begin
        o_valid <= store;
        if (store) o_q <= dec;
      end
    end else if (store) begin
      k_q     <= dec;
      k_valid <= 1'b1;
    end
  end

  assign bus.out_valid_o = o_valid;
  assign bus.instr_o     = o_q.instr;
  assign bus.imm_o       = o_q.imm;
  assign bus.fmt_o       = o_q.fmt;
  assign bus.illegal_o   = o_q.illegal;
`ifdef IMM_PC_TARGET_EN
  assign bus.target_o    = o_q.target;
`endif

endmodule
